// File: rtl/sar_afe_model.sv
// sar_afe_model: digital stand-in for the SAR ADC analog front end.
// It holds a stimulus FIFO of analog codes. A sample strobe pops the head of
// the FIFO into the hold register. The comparator returns (held >= dac) to
// the controller. The block also checks the controller's conversion timing
// and counts completed conversions.
//
// Ports:
//   clk_i        clock
//   rst_i        asynchronous reset, active-high
//   vin_i        analog input code to enqueue
//   vin_valid_i  vin_i valid
//   vin_ready_o  FIFO can accept an entry (registered)
//   sample_i     sample strobe from controller
//   dac_i        DAC code from controller
//   eoc_i        end-of-conversion / idle flag from controller
//   cmp_o        comparator decision (combinational when CmpLat == 0)
//   held_o       current held code
//   underrun_o   sticky: sample taken with FIFO empty
//   proto_err_o  sticky: controller timing violation
//   conv_cnt_o   completed conversions, wraps at 16 bits
//
// Optional feature macro: CMP_DITHER_EN. When it is defined, an 8-bit LFSR
// alternates the compare between > and >=. This models +/- 1/2 LSB noise.
// Depth must be a power of two and at least 2.

module sar_afe_model #(
  parameter int unsigned Width  = 6,
  parameter int unsigned Depth  = 4,
  parameter int unsigned CmpLat = 0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [Width-1:0] vin_i,
  input  logic             vin_valid_i,
  output logic             vin_ready_o,
  input  logic             sample_i,
  input  logic [Width-1:0] dac_i,
  input  logic             eoc_i,
  output logic             cmp_o,
  output logic [Width-1:0] held_o,
  output logic             underrun_o,
  output logic             proto_err_o,
  output logic [15:0]      conv_cnt_o
);

  localparam int unsigned AddrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned PtrW  = AddrW + 1;
  localparam int unsigned CntW  = $clog2(Width + 3);
  localparam logic [CntW-1:0] CntDone = CntW'(Width + 1);
  localparam logic [CntW-1:0] CntMax  = CntW'(Width + 2);

  // ---------------------------------------------------------------------------
  // Stimulus FIFO. The pointers carry an extra wrap bit so that full and empty
  // can be told apart.
  // ---------------------------------------------------------------------------
  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [PtrW-1:0]  wr_ptr_d, rd_ptr_d;
  logic             fifo_empty;
  logic             push, pop;

  function automatic logic ptrs_full(input logic [PtrW-1:0] w,
                                     input logic [PtrW-1:0] r);
    return (w[AddrW-1:0] == r[AddrW-1:0]) && (w[AddrW] != r[AddrW]);
  endfunction

  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign push       = vin_valid_i && vin_ready_o;
  assign pop        = sample_i && !fifo_empty;
  assign wr_ptr_d   = wr_ptr_q + PtrW'(push);
  assign rd_ptr_d   = rd_ptr_q + PtrW'(pop);

  // Pointer and ready state. Ready is precomputed from the next pointers, so it
  // comes straight from a flop.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      vin_ready_o <= 1'b1;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      vin_ready_o <= !ptrs_full(wr_ptr_d, rd_ptr_d);
    end
  end

  // Storage needs no reset: the pointers define which entries are valid.
  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_q[wr_ptr_q[AddrW-1:0]] <= vin_i;
    end
  end

  // ---------------------------------------------------------------------------
  // Sample-and-hold. A sample on an empty FIFO keeps the old value and flags
  // an underrun. There is no bypass, so a push in the same cycle does not help.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      held_o     <= '0;
      underrun_o <= 1'b0;
    end else begin
      if (pop) begin
        held_o <= mem_q[rd_ptr_q[AddrW-1:0]];
      end
      if (sample_i && fifo_empty) begin
        underrun_o <= 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Comparator
  // ---------------------------------------------------------------------------
  logic cmp_raw;

`ifdef CMP_DITHER_EN
  logic [7:0] lfsr_q;

  // Fibonacci LFSR, taps 8,6,5,4; free-running.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      lfsr_q <= 8'h01;
    end else begin
      lfsr_q <= {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    end
  end

  // When lfsr[0] is set, the compare is strict; otherwise it is inclusive.
  assign cmp_raw = lfsr_q[0] ? (held_o > dac_i) : (held_o >= dac_i);
`else
  assign cmp_raw = (held_o >= dac_i);
`endif

  generate
    if (CmpLat == 0) begin : g_cmp_comb
      assign cmp_o = cmp_raw;
    end else begin : g_cmp_pipe
      logic [CmpLat-1:0] pipe_q;

      // Delay line of CmpLat stages; the decision emerges from the last stage.
      always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
          pipe_q <= '0;
        end else begin
          pipe_q[0] <= cmp_raw;
          for (int i = 1; i < int'(CmpLat); i++) begin
            pipe_q[i] <= pipe_q[i-1];
          end
        end
      end

      assign cmp_o = pipe_q[CmpLat-1];
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Protocol monitor and conversion counter.
  // The legal sequence is: one sample cycle, Width decision cycles, one done
  // cycle, and then eoc. At eoc the bit counter must therefore read Width+1.
  // ---------------------------------------------------------------------------
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_CONV = 1'b1
  } mon_state_e;

  mon_state_e      state_q;
  logic [CntW-1:0] bit_cnt_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      bit_cnt_q   <= '0;
      proto_err_o <= 1'b0;
      conv_cnt_o  <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (sample_i) begin
            state_q   <= ST_CONV;
            bit_cnt_q <= '0;
          end else if (!eoc_i) begin
            proto_err_o <= 1'b1;
          end
        end
        ST_CONV: begin
          if (sample_i) begin
            // A re-sample mid-conversion restarts the timing check.
            proto_err_o <= 1'b1;
            bit_cnt_q   <= '0;
          end else if (eoc_i) begin
            state_q    <= ST_IDLE;
            conv_cnt_o <= conv_cnt_o + 16'd1;
            if (bit_cnt_q != CntDone) begin
              proto_err_o <= 1'b1;
            end
          end else if (bit_cnt_q != CntMax) begin
            bit_cnt_q <= bit_cnt_q + CntW'(1);
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sar_afe_model.sv
// Bench for sar_afe_model. It instantiates two copies that share all inputs:
// dut0 has CmpLat=0 and dut1 has CmpLat=1. The bench acts as the SAR
// controller: it performs a binary search against the chosen copy's cmp_o.
// FIFO codes go into a scoreboard queue when pushed. They are popped and
// compared when a conversion returns its result.
module tb_sar_afe_model;

  localparam int unsigned W = 6;

  logic         clk = 1'b0;
  logic         rst_i = 1'b1;
  logic [W-1:0] vin_i = '0;
  logic         vin_valid_i = 1'b0;
  logic         sample_i = 1'b0;
  logic [W-1:0] dac_i = W'(1);
  logic         eoc_i = 1'b1;

  logic         ready0, cmp0, underrun0, proto0;
  logic [W-1:0] held0;
  logic [15:0]  cnt0;
  logic         ready1, cmp1, underrun1, proto1;
  logic [W-1:0] held1;
  logic [15:0]  cnt1;

  always #5 clk = ~clk;

  sar_afe_model #(.Width(W), .Depth(4), .CmpLat(0)) dut0 (
    .clk_i(clk), .rst_i(rst_i), .vin_i(vin_i), .vin_valid_i(vin_valid_i),
    .vin_ready_o(ready0), .sample_i(sample_i), .dac_i(dac_i), .eoc_i(eoc_i),
    .cmp_o(cmp0), .held_o(held0), .underrun_o(underrun0),
    .proto_err_o(proto0), .conv_cnt_o(cnt0)
  );

  sar_afe_model #(.Width(W), .Depth(4), .CmpLat(1)) dut1 (
    .clk_i(clk), .rst_i(rst_i), .vin_i(vin_i), .vin_valid_i(vin_valid_i),
    .vin_ready_o(ready1), .sample_i(sample_i), .dac_i(dac_i), .eoc_i(eoc_i),
    .cmp_o(cmp1), .held_o(held1), .underrun_o(underrun1),
    .proto_err_o(proto1), .conv_cnt_o(cnt1)
  );

  int checks = 0;
  int failures = 0;
  logic [W-1:0] exp_q[$];

  typedef struct {
    logic [W-1:0] vin;
    logic [W-1:0] exp_res;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_i = 1'b1; sample_i = 1'b0; vin_valid_i = 1'b0; eoc_i = 1'b1; dac_i = W'(1);
    @(negedge clk);
    @(negedge clk);
    rst_i = 1'b0;
    @(negedge clk);
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_ready"}, 32'(ready0), 32'd1);
    check({tag, "_held"}, 32'(held0), 32'd0);
    check({tag, "_cmp0"}, 32'(cmp0), 32'd0);
    check({tag, "_cmp1"}, 32'(cmp1), 32'd0);
    check({tag, "_underrun"}, 32'(underrun0), 32'd0);
    check({tag, "_proto"}, 32'(proto0), 32'd0);
    check({tag, "_cnt"}, 32'(cnt0), 32'd0);
  endtask

  task automatic push_code(input logic [W-1:0] c);
    @(negedge clk);
    vin_i = c; vin_valid_i = 1'b1;
    @(negedge clk);
    vin_valid_i = 1'b0;
  endtask

  // Nominal conversion: sample, W decisions, done cycle, eoc.
  task automatic run_conv(input bit sel, input bit do_push, input logic [W-1:0] pcode,
                          output logic [W-1:0] res);
    logic [W-1:0] code;
    logic [W-1:0] trial;
    code = '0;
    @(negedge clk);
    sample_i = 1'b1; eoc_i = 1'b0; dac_i = '0;
    if (do_push) begin
      vin_i = pcode; vin_valid_i = 1'b1;
    end
    @(negedge clk);
    sample_i = 1'b0; vin_valid_i = 1'b0;
    for (int k = W - 1; k >= 0; k--) begin
      trial = code | (W'(1) << k);
      dac_i = trial;
      #1;
      if ((sel ? cmp1 : cmp0) == 1'b1) code = trial;
      @(negedge clk);
    end
    dac_i = code;
    @(negedge clk);
    eoc_i = 1'b1;
    @(negedge clk);
    res = code;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] res;
    logic [W-1:0] exp;
    vec_t vecs[6];
    logic [W-1:0] fill[4];

    vecs[0] = '{6'h2A, 6'h2A};
    vecs[1] = '{6'h00, 6'h00};
    vecs[2] = '{6'h3F, 6'h3F};
    vecs[3] = '{6'h15, 6'h15};
    vecs[4] = '{6'h01, 6'h01};
    vecs[5] = '{6'h20, 6'h20};
    fill[0] = 6'h11; fill[1] = 6'h22; fill[2] = 6'h33; fill[3] = 6'h04;

    do_reset();
    check_reset("por");

    // Sample on an empty FIFO right after reset.
    run_conv(1'b0, 1'b0, '0, res);
    check("ur_result", 32'(res), 32'h00);
    check("ur_flag", 32'(underrun0), 32'd1);
    check("ur_held", 32'(held0), 32'h00);
    check("ur_cnt", 32'(cnt0), 32'd1);
    check("ur_proto", 32'(proto0), 32'd0);
    do_reset();
    check_reset("rst1");

    // Table-driven nominal conversions.
    for (int i = 0; i < 6; i++) begin
      push_code(vecs[i].vin);
      exp_q.push_back(vecs[i].exp_res);
      run_conv(1'b0, 1'b0, '0, res);
      exp = exp_q.pop_front();
      check($sformatf("vec%0d_result", i), 32'(res), 32'(exp));
      check($sformatf("vec%0d_held", i), 32'(held0), 32'(vecs[i].vin));
    end
    check("vec_cnt", 32'(cnt0), 32'd6);
    check("vec_proto", 32'(proto0), 32'd0);
    check("vec_underrun", 32'(underrun0), 32'd0);

    // Fill the FIFO, then push once more into a full FIFO.
    for (int i = 0; i < 4; i++) begin
      push_code(fill[i]);
      exp_q.push_back(fill[i]);
      check($sformatf("fill%0d_ready", i), 32'(ready0), (i < 3) ? 32'd1 : 32'd0);
    end
    push_code(6'h3E);
    check("full_ready", 32'(ready0), 32'd0);
    for (int i = 0; i < 4; i++) begin
      run_conv(1'b0, 1'b0, '0, res);
      exp = exp_q.pop_front();
      check($sformatf("drain%0d_result", i), 32'(res), 32'(exp));
    end
    check("drain_ready", 32'(ready0), 32'd1);
    check("drain_underrun", 32'(underrun0), 32'd0);
    check("drain_cnt", 32'(cnt0), 32'd10);

    // Push and sample in the same cycle on an empty FIFO.
    run_conv(1'b0, 1'b1, 6'h2D, res);
    check("pushsamp_underrun", 32'(underrun0), 32'd1);
    check("pushsamp_result", 32'(res), 32'(fill[3]));
    exp_q.push_back(6'h2D);
    run_conv(1'b0, 1'b0, '0, res);
    exp = exp_q.pop_front();
    check("pushsamp_kept", 32'(res), 32'(exp));
    check("pushsamp_proto", 32'(proto0), 32'd0);

    // CmpLat=1: each decision sees the previous cycle's compare.
    push_code(6'h15);
    run_conv(1'b1, 1'b0, '0, res);
    check("lat1_result", 32'(res), 32'h20);
    check("lat1_held", 32'(held1), 32'h15);
    check("lat1_proto", 32'(proto1), 32'd0);
    check("lat1_cnt", 32'(cnt1), 32'd13);

    // Re-sample 3 cycles after a sample.
    do_reset();
    @(negedge clk); sample_i = 1'b1; eoc_i = 1'b0;
    @(negedge clk); sample_i = 1'b0;
    @(negedge clk);
    @(negedge clk); sample_i = 1'b1;
    @(negedge clk); sample_i = 1'b0;
    check("resample_proto", 32'(proto0), 32'd1);
    eoc_i = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("resample_sticky", 32'(proto0), 32'd1);
    do_reset();
    check_reset("rst2");

    // eoc after only 5 decisions.
    @(negedge clk); sample_i = 1'b1; eoc_i = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk); sample_i = 1'b0;
    end
    @(negedge clk); eoc_i = 1'b1;
    @(negedge clk);
    check("early_eoc_proto", 32'(proto0), 32'd1);
    check("early_eoc_cnt", 32'(cnt0), 32'd1);
    do_reset();
    check_reset("rst3");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
